// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M/RV64M multiply-divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational datapath: UNROLL shift-add (multiply) or restoring-subtract (divide)
// iterations on the {acc, opr} register pair.
module muldiv_step #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] opr_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] opr_o
);

  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] opr;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  // Multiply: acc:opr shifts right, multiplier consumed from opr LSB.
  // Divide: dividend bits enter acc from opr MSB, quotient bits fill opr LSB.
  always_comb begin
    acc    = acc_i;
    opr    = opr_i;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (is_div_i) begin
        rem_sh = {acc, opr[XLEN-1]};
        diff   = rem_sh - {1'b0, d_i};
        opr    = {opr[XLEN-2:0], ~diff[XLEN]};
        acc    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      end else begin
        sum = {1'b0, acc} + (opr[0] ? {1'b0, d_i} : {(XLEN+1){1'b0}});
        opr = {sum[0], opr[XLEN-1:1]};
        acc = sum[XLEN:1];
      end
    end
    acc_o = acc;
    opr_o = opr;
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide execute unit: valid/ready request in, XLEN/UNROLL compute cycles,
// result held until writeback accepts it. Divide-by-zero and MIN/-1 resolve without iterating.
module alu_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned STEPS = XLEN / UNROLL;
  localparam int unsigned CW    = $clog2(STEPS) + 1;

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] opr_q, opr_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  md_op_e            op_in;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   min_val;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   step_acc, step_opr;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fin;

  // Request decode: operand magnitudes and the two early-out divide cases
  always_comb begin
    op_in    = md_op_e'(funct3);
    sa       = is_signed_a(op_in) & op_a[XLEN-1];
    sb       = is_signed_b(op_in) & op_b[XLEN-1];
    a_mag    = sa ? (-op_a) : op_a;
    b_mag    = sb ? (-op_b) : op_b;
    min_val  = {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (op_b == '0);
    div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) && (op_a == min_val) && (op_b == '1);
  end

  muldiv_step #(
    .XLEN  (XLEN),
    .UNROLL(UNROLL)
  ) u_step (
    .is_div_i(is_div(op_q)),
    .acc_i   (acc_q),
    .opr_i   (opr_q),
    .d_i     (dvs_q),
    .acc_o   (step_acc),
    .opr_o   (step_opr)
  );

  // Sign fix-up and field select on the final iteration's output
  always_comb begin
    prod     = {step_acc, step_opr};
    prod_fix = neg_q ? (-prod) : prod;
    quo_fix  = neg_q ? (-step_opr) : step_opr;
    rem_fix  = neg_rem_q ? (-step_acc) : step_acc;
    unique case (op_q)
      MD_MUL:                     fin = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            fin = quo_fix;
      default:                    fin = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    opr_d     = opr_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d      = op_in;
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          if (is_div(op_in) && div_zero) begin
            result_d = is_rem(op_in) ? op_a : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = is_rem(op_in) ? '0 : min_val;
            state_d  = DONE;
          end else begin
            acc_d   = '0;
            opr_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CW'(STEPS);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          opr_d = step_opr;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = fin;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      opr_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      opr_q     <= opr_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // A redirect in the same cycle must never let a new request in
  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule
